// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-access stage controller between EX/MEM and MEM/WB.
//
// Issues loads and stores to a variable-latency data memory, stalls the
// upstream pipeline while an access is outstanding, and presents the WB
// control bits, ALU result, load data and destination register to MEM/WB.
// A Halt instruction freezes the stage, and a memory timeout raises a
// sticky error. Both conditions are held until reset.
//
// Handshake: dmem_req rises on the edge that accepts a load/store. It
// stays high, with dmem_we/dmem_addr/dmem_wdata stable, until the edge
// after the cycle in which dmem_ack pulses. dmem_rdata is sampled only in
// that ack cycle. An ack seen while no access is outstanding is ignored.
//
// Ports:
//   clk, rst              clock (rising edge), async active-low reset
//   ex_valid              EX/MEM holds a valid instruction
//   WB_in[3:0]            {RegWrite, MemtoReg, PCtoReg, Halt}
//   MemRead, MemWrite     load / store (both set = store)
//   alu_result[15:0]      ALU result / memory address
//   store_data[15:0]      store write data
//   DstReg_in[3:0]        destination register
//   dmem_req/we/addr/wdata registered memory request
//   dmem_ack, dmem_rdata  memory completion pulse and read data
//   stall                 upstream must hold EX/MEM contents
//   wb_valid              MEM/WB outputs carry a real instruction
//   WB_out, reg_data_out, dmem_out, DstReg_out   MEM/WB payload
//   mem_err               sticky timeout flag
//   state_dbg[1:0]        current FSM state (0 IDLE, 1 WAIT, 2 HALTED, 3 ERR)

module mem_stage_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [3:0]  WB_in,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [15:0] alu_result,
    input  logic [15:0] store_data,
    input  logic [3:0]  DstReg_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [15:0] dmem_rdata,
    output logic        stall,
    output logic        wb_valid,
    output logic [3:0]  WB_out,
    output logic [15:0] reg_data_out,
    output logic [15:0] dmem_out,
    output logic [3:0]  DstReg_out,
    output logic        mem_err,
    output logic [1:0]  state_dbg
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;
    localparam logic [1:0] S_ERR    = 2'd3;

    // Counter value in the last WAIT cycle that may still be rescued by an ack.
    localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

    logic [1:0] state;
    logic [3:0] cnt;
    logic [3:0] cap_wb;
    logic [3:0] cap_dst;
    logic       mem_op;

    assign mem_op    = MemRead | MemWrite;
    assign state_dbg = state;

    // dmem_addr doubles as the captured ALU result for the retiring access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            cap_wb     <= 4'd0;
            cap_dst    <= 4'd0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 16'd0;
            dmem_wdata <= 16'd0;
            mem_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ex_valid) begin
                        if (mem_op) begin
                            cap_wb     <= WB_in;
                            cap_dst    <= DstReg_in;
                            dmem_req   <= 1'b1;
                            dmem_we    <= MemWrite;
                            dmem_addr  <= alu_result;
                            dmem_wdata <= store_data;
                            cnt        <= 4'd0;
                            state      <= S_WAIT;
                        end else if (WB_in[0]) begin
                            state <= S_HALTED;
                        end
                    end
                end
                S_WAIT: begin
                    // Ack is checked first so it wins over a timeout in the same cycle.
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        state    <= cap_wb[0] ? S_HALTED : S_IDLE;
                    end else if (cnt == CNT_LAST) begin
                        dmem_req <= 1'b0;
                        mem_err  <= 1'b1;
                        state    <= S_ERR;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

    // Outputs are gated by rst so they read 0 for the whole reset window,
    // including the instant an async reset lands mid-access.
    always_comb begin
        stall        = 1'b0;
        wb_valid     = 1'b0;
        WB_out       = 4'd0;
        reg_data_out = 16'd0;
        dmem_out     = 16'd0;
        DstReg_out   = 4'd0;
        if (rst) begin
            case (state)
                S_IDLE: begin
                    if (ex_valid) begin
                        if (mem_op) begin
                            stall = 1'b1;
                        end else begin
                            wb_valid     = 1'b1;
                            WB_out       = WB_in;
                            reg_data_out = alu_result;
                            DstReg_out   = DstReg_in;
                        end
                    end
                end
                S_WAIT: begin
                    if (dmem_ack) begin
                        wb_valid     = 1'b1;
                        WB_out       = cap_wb;
                        reg_data_out = dmem_addr;
                        DstReg_out   = cap_dst;
                        dmem_out     = dmem_we ? 16'd0 : dmem_rdata;
                    end else begin
                        stall = 1'b1;
                    end
                end
                default: begin
                    stall = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Testbench for mem_stage_ctrl: directed scenarios followed by randomized
// segments, all compared against a transaction-level reference model.
module tb_mem_stage_ctrl;

    localparam int TIMEOUT = 15;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        ex_valid = 1'b0;
    logic [3:0]  WB_in = 4'd0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [15:0] alu_result = 16'd0;
    logic [15:0] store_data = 16'd0;
    logic [3:0]  DstReg_in = 4'd0;
    logic        dmem_ack = 1'b0;
    logic [15:0] dmem_rdata = 16'd0;

    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic        stall;
    logic        wb_valid;
    logic [3:0]  WB_out;
    logic [15:0] reg_data_out;
    logic [15:0] dmem_out;
    logic [3:0]  DstReg_out;
    logic        mem_err;
    logic [1:0]  state_dbg;

    mem_stage_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .WB_in(WB_in),
        .MemRead(MemRead), .MemWrite(MemWrite), .alu_result(alu_result),
        .store_data(store_data), .DstReg_in(DstReg_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall(stall), .wb_valid(wb_valid), .WB_out(WB_out),
        .reg_data_out(reg_data_out), .dmem_out(dmem_out),
        .DstReg_out(DstReg_out), .mem_err(mem_err), .state_dbg(state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: an access is "pending" from its accept edge until the
    // edge closing its ack cycle; the stage dies after TIMEOUT unacked waits.
    bit          m_halted;
    bit          m_errored;
    bit          m_pending;
    int          m_waited;
    logic        m_we;
    logic [15:0] m_addr;
    logic [15:0] m_wdata;
    // Retiring memory ops: {WB, Dst, address}.
    logic [23:0] exp_q[$];

    task automatic model_reset();
        m_halted  = 0;
        m_errored = 0;
        m_pending = 0;
        m_waited  = 0;
        m_we      = 1'b0;
        m_addr    = 16'd0;
        m_wdata   = 16'd0;
        exp_q.delete();
    endtask

    // Advance the model by one clock edge using the inputs seen before it.
    task automatic model_step();
        if (m_halted || m_errored) return;
        if (m_pending) begin
            if (dmem_ack) begin
                m_pending = 0;
                if (exp_q.size() > 0) begin
                    if (exp_q[0][20]) m_halted = 1;
                    void'(exp_q.pop_front());
                end
            end else begin
                m_waited++;
                if (m_waited >= TIMEOUT) begin
                    m_errored = 1;
                    m_pending = 0;
                end
            end
        end else if (ex_valid) begin
            if (MemRead || MemWrite) begin
                m_pending = 1;
                m_waited  = 0;
                m_we      = MemWrite;
                m_addr    = alu_result;
                m_wdata   = store_data;
                exp_q.push_back({WB_in, DstReg_in, alu_result});
            end else if (WB_in[0]) begin
                m_halted = 1;
            end
        end
    endtask

    task automatic check_outputs();
        logic        e_stall;
        logic        e_wbv;
        logic [3:0]  e_wb;
        logic [15:0] e_rd;
        logic [15:0] e_dout;
        logic [3:0]  e_dst;
        logic [23:0] front;
        e_stall = 1'b0; e_wbv = 1'b0; e_wb = 4'd0; e_rd = 16'd0; e_dout = 16'd0; e_dst = 4'd0;
        if (!rst) begin
            e_stall = 1'b0;
        end else if (m_halted || m_errored) begin
            e_stall = 1'b1;
        end else if (m_pending) begin
            if (dmem_ack) begin
                if (exp_q.size() == 0) begin
                    check("exp_q_empty", 16'd0, 16'd1);
                    front = 24'd0;
                end else begin
                    front = exp_q[0];
                end
                e_wbv  = 1'b1;
                e_wb   = front[23:20];
                e_dst  = front[19:16];
                e_rd   = front[15:0];
                e_dout = m_we ? 16'd0 : dmem_rdata;
            end else begin
                e_stall = 1'b1;
            end
        end else if (ex_valid) begin
            if (MemRead || MemWrite) begin
                e_stall = 1'b1;
            end else begin
                e_wbv = 1'b1;
                e_wb  = WB_in;
                e_rd  = alu_result;
                e_dst = DstReg_in;
            end
        end
        check("stall", 16'(stall), 16'(e_stall));
        check("wb_valid", 16'(wb_valid), 16'(e_wbv));
        check("WB_out", 16'(WB_out), 16'(e_wb));
        check("reg_data_out", reg_data_out, e_rd);
        check("dmem_out", dmem_out, e_dout);
        check("DstReg_out", 16'(DstReg_out), 16'(e_dst));
        check("dmem_req", 16'(dmem_req), 16'(rst && m_pending));
        check("mem_err", 16'(mem_err), 16'(rst && m_errored));
        if (rst && m_pending) begin
            check("dmem_we", 16'(dmem_we), 16'(m_we));
            check("dmem_addr", dmem_addr, m_addr);
            check("dmem_wdata", dmem_wdata, m_wdata);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change at posedge+1; outputs are checked at the falling edge.
    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid = 1'b0; WB_in = 4'd0; MemRead = 1'b0; MemWrite = 1'b0;
        alu_result = 16'd0; store_data = 16'd0; DstReg_in = 4'd0;
        dmem_ack = 1'b0; dmem_rdata = 16'd0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        model_reset();
        #2;
        check_outputs();
        check("rst_dmem_we", 16'(dmem_we), 16'd0);
        check("rst_dmem_addr", dmem_addr, 16'd0);
        check("rst_dmem_wdata", dmem_wdata, 16'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [3:0] wb,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [3:0] dst);
        ex_valid = 1'b1; MemRead = rd; MemWrite = wr; WB_in = wb;
        alu_result = addr; store_data = wdata; DstReg_in = dst;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        do_reset();

        // ALU pass-through.
        issue(1'b0, 1'b0, 4'b1000, 16'h1234, 16'h0000, 4'h5);
        tick();
        idle_inputs();
        tick();

        // Load, ack after 3 WAIT cycles.
        issue(1'b1, 1'b0, 4'b1100, 16'h0040, 16'h0000, 4'h3);
        tick();
        for (int i = 0; i < 3; i++) tick();
        dmem_ack = 1'b1; dmem_rdata = 16'hBEEF;
        tick();
        idle_inputs();
        tick();

        // Store, ack on first WAIT cycle.
        issue(1'b0, 1'b1, 4'b0000, 16'h0010, 16'hA5A5, 4'h0);
        tick();
        dmem_ack = 1'b1; dmem_rdata = 16'h5555;
        tick();
        idle_inputs();
        tick();

        // Read and write together behave as a store.
        issue(1'b1, 1'b1, 4'b1000, 16'h0022, 16'h7777, 4'h9);
        tick();
        dmem_ack = 1'b1; dmem_rdata = 16'h1111;
        tick();
        idle_inputs();
        tick();

        // Ack on the last rescuable WAIT cycle wins over the timeout.
        issue(1'b1, 1'b0, 4'b1100, 16'h0300, 16'h0000, 4'h2);
        tick();
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        dmem_ack = 1'b1; dmem_rdata = 16'hCAFE;
        tick();
        idle_inputs();
        tick();

        // Timeout, then a late ack, then reset clears the error.
        issue(1'b1, 1'b0, 4'b1100, 16'h0080, 16'h0000, 4'h7);
        tick();
        for (int i = 0; i < TIMEOUT + 3; i++) tick();
        idle_inputs();
        dmem_ack = 1'b1; dmem_rdata = 16'hDEAD;
        tick();
        do_reset();

        // Halt: passes once, then the stage freezes.
        issue(1'b0, 1'b0, 4'b0001, 16'h0abc, 16'h0000, 4'h1);
        tick();
        issue(1'b1, 1'b0, 4'b1100, 16'h0090, 16'h0000, 4'h4);
        for (int i = 0; i < 4; i++) tick();
        do_reset();

        // Async reset between edges while an access is outstanding.
        issue(1'b1, 1'b0, 4'b1100, 16'h0050, 16'h0000, 4'h6);
        tick();
        tick();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_outputs();
        check("async_req", 16'(dmem_req), 16'd0);
        check("async_stall", 16'(stall), 16'd0);
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        issue(1'b0, 1'b0, 4'b1010, 16'h4321, 16'h0000, 4'hA);
        tick();
        idle_inputs();
        tick();

        // Randomized segments, each starting from reset.
        for (int seg = 0; seg < 30; seg++) begin
            bit never_ack;
            do_reset();
            never_ack = ($urandom_range(0, 5) == 0);
            for (int cyc = 0; cyc < 40; cyc++) begin
                ex_valid   = ($urandom_range(0, 3) != 0);
                MemRead    = $urandom_range(0, 1);
                MemWrite   = $urandom_range(0, 1);
                WB_in      = {3'($urandom_range(0, 7)), ($urandom_range(0, 15) == 0)};
                alu_result = 16'($urandom);
                store_data = 16'($urandom);
                DstReg_in  = 4'($urandom_range(0, 15));
                dmem_ack   = never_ack ? 1'b0 : ($urandom_range(0, 2) == 0);
                dmem_rdata = 16'($urandom);
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
